mac_accumulate_stage: RTL and testbench



---
 rtl/mac_pkg.sv | 17 +
 rtl/mac_accumulate_stage_wtm.sv | 45 ++++
 rtl/mac_accumulate_stage.sv | 128 ++++++++++++
 tb/tb_mac_accumulate_stage.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared constants and types for the MAC accumulate stage.
package mac_pkg;

  localparam int OP_W   = 5;
  localparam int PROD_W = 10;

  typedef enum logic [1:0] {
    ACCUM,
    DRAIN,
    DONE
  } state_e;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mac_accumulate_stage_wtm.sv
// Combinational 5x5 unsigned Wallace tree multiplier.
module wtm
  import mac_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] p,
  output logic              cout
);

  localparam int W = PROD_W + 1;

  function automatic logic [2*W-1:0] csa(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic [W-1:0] z
  );
    logic [W-1:0] s;
    logic [W-1:0] c;
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
    return {c, s};
  endfunction

  logic [W-1:0] pp [OP_W];
  logic [W-1:0] s0, c0, s1, c1, s2, c2;
  logic [W-1:0] tot;

  always_comb begin
    for (int i = 0; i < OP_W; i++) begin
      pp[i] = W'(a & {OP_W{b[i]}}) << i;
    end
  end

  // Three 3:2 levels reduce five rows to two, then one final add.
  always_comb begin
    {c0, s0} = csa(pp[0], pp[1], pp[2]);
    {c1, s1} = csa(pp[3], pp[4], s0);
    {c2, s2} = csa(c0, c1, s1);
    tot      = s2 + c2;
    p        = tot[PROD_W-1:0];
    cout     = tot[W-1];
  end

endmodule

// File: rtl/mac_accumulate_stage.sv
// Multiply-accumulate stage: sums N_TERMS wtm products per result.
// Define MAC_ACC_SAT_EN to saturate instead of wrap on overflow.
module mac_accumulate_stage
  import mac_pkg::*;
#(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 12
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW = cnt_w(N_TERMS);
  localparam int SW = ACC_W + 1;
  localparam logic [CW-1:0] LAST = CW'(N_TERMS - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [OP_W-1:0] a_q, a_d;
  logic [OP_W-1:0] b_q, b_d;
  logic            v1_q, v1_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic            ovf_q, ovf_d;

  logic [PROD_W-1:0] prod;
  logic              unused_cout;
  logic [SW-1:0]     sum_ext;
  logic              accept;

  wtm u_wtm (
    .a    (a_q),
    .b    (b_q),
    .p    (prod),
    .cout (unused_cout)
  );

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;
  assign accept    = in_valid && in_ready;
  assign sum_ext   = {1'b0, acc_q} + SW'(prod);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    v1_d    = accept;
    acc_d   = acc_q;
    ovf_d   = ovf_q;

    if (accept) begin
      a_d = in_a;
      b_d = in_b;
    end

    if (v1_q) begin
      acc_d = sum_ext[ACC_W-1:0];
      if (sum_ext[ACC_W]) begin
        ovf_d = 1'b1;
`ifdef MAC_ACC_SAT_EN
        acc_d = '1;
`endif
      end
    end

    unique case (state_q)
      ACCUM: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = DRAIN;
        end
      end
      // Last product is still in the operand regs until v1 clears.
      DRAIN: begin
        if (!v1_q) state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase

    if (flush) begin
      acc_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
      v1_d    = 1'b0;
      state_d = ACCUM;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      v1_q    <= 1'b0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      v1_q    <= v1_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mac_accumulate_stage.sv
// Scoreboard bench for mac_accumulate_stage (ACC_W=12 and ACC_W=10 copies).
module tb_mac_accumulate_stage;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  in_a = '0;
  logic [4:0]  in_b = '0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_ovf;
  logic [11:0] out_sum;
  logic        in_ready10, out_valid10, out_ovf10;
  logic [9:0]  out_sum10;

  always #5 clock = ~clock;

  mac_accumulate_stage #(.N_TERMS(4), .ACC_W(12)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  mac_accumulate_stage #(.N_TERMS(4), .ACC_W(10)) dut10 (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_valid  (in_valid),
    .in_ready  (in_ready10),
    .flush     (flush),
    .out_sum   (out_sum10),
    .out_ovf   (out_ovf10),
    .out_valid (out_valid10),
    .out_ready (out_ready)
  );

  typedef struct {
    int s12;
    int o12;
    int s10;
    int o10;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  int m12, m10, o12, o10, cnt;
  bit done = 1'b0;

`ifdef MAC_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic model_clear();
    m12 = 0; m10 = 0; o12 = 0; o10 = 0; cnt = 0;
  endtask

  task automatic model_add(input int a, input int b);
    int t;
    exp_t e;
    t = m12 + a * b;
    if (t >= 4096) begin
      o12 = 1;
      m12 = SAT ? 4095 : t - 4096;
    end else m12 = t;
    t = m10 + a * b;
    if (t >= 1024) begin
      o10 = 1;
      m10 = SAT ? 1023 : t - 1024;
    end else m10 = t;
    cnt++;
    if (cnt == 4) begin
      e.s12 = m12; e.o12 = o12; e.s10 = m10; e.o10 = o10;
      q.push_back(e);
      model_clear();
    end
  endtask

  task automatic send(input int a, input int b);
    int n;
    in_a = 5'(a);
    in_b = 5'(b);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      chk("send_timeout", in_ready, 1);
    end else begin
      step();
      model_add(a, b);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    chk("valid_timeout", out_valid, 1);
  endtask

  // Handshake decided here completes at the following rising edge.
  always @(negedge clock) begin
    if (reset_n && !flush && out_valid && out_ready) begin
      chk("queue_nonempty", q.size() > 0, 1);
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        chk("sum12", out_sum, mon_e.s12);
        chk("ovf12", out_ovf, mon_e.o12);
        chk("valid10", out_valid10, 1);
        chk("sum10", out_sum10, mon_e.s10);
        chk("ovf10", out_ovf10, mon_e.o10);
      end
    end
  end

  initial begin
    int n;
    model_clear();

    reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_ovf", out_ovf, 0);

    // Back-to-back terms, latency, and hold under backpressure
    out_ready = 1'b0;
    send(3, 5);
    send(31, 31);
    send(0, 17);
    send(1, 1);
    chk("drain_in_ready", in_ready, 0);
    chk("lat_valid_0", out_valid, 0);
    step();
    chk("lat_valid_1", out_valid, 0);
    chk("lat_in_ready_1", in_ready, 0);
    step();
    chk("lat_valid_2", out_valid, 1);
    chk("done_in_ready", in_ready, 0);
    chk("sum_977", out_sum, 977);
    chk("ovf_977", out_ovf, 0);
    repeat (5) begin
      step();
      chk("hold_sum", out_sum, 977);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("post_hs_in_ready", in_ready, 1);
    chk("post_hs_valid", out_valid, 0);

    repeat (4) send(2, 2);
    wait_valid();
    chk("sum_16", out_sum, 16);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Flush drops a partial result
    send(31, 31);
    send(31, 31);
    flush = 1'b1;
    step();
    flush = 1'b0;
    model_clear();
    chk("flush_in_ready", in_ready, 1);
    chk("flush_valid", out_valid, 0);
    chk("flush_sum", out_sum, 0);
    repeat (4) send(1, 1);
    wait_valid();
    chk("flush_sum_4", out_sum, 4);
    chk("flush_ovf", out_ovf, 0);
    chk("flush_one_result", q.size(), 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("flush_q_empty", q.size(), 0);

    // Overflow on the narrow copy
    repeat (4) send(31, 31);
    wait_valid();
    chk("ovf_sum12", out_sum, 3844);
    chk("ovf_sum10", out_sum10, SAT ? 1023 : 772);
    chk("ovf_flag10", out_ovf10, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset mid-operation
    send(7, 7);
    send(9, 9);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    model_clear();
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_sum", out_sum, 0);

    // Random traffic with gaps and backpressure
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
          send($urandom_range(0, 31), $urandom_range(0, 31));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = 1'($urandom_range(0, 1));
          step();
        end
      end
    join
    out_ready = 1'b1;
    n = 0;
    while (q.size() > 0 && n < 100) begin
      step();
      n++;
    end
    chk("rand_q_empty", q.size(), 0);
    chk("rand_no_partial", cnt, 0);
    chk("rand_final_idle", in_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
